// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable clock divider / clock-enable generator.
//
// Divides clk by any integer N >= 2. clk_out is low for floor(N/2) cycles and
// high for ceil(N/2) cycles. tick is a one-cycle enable in the last high cycle.
// A new divisor is requested with div_load/div_in. It is held pending and is
// applied only on a period boundary, or on the next cycle while parked, so
// clk_out never glitches.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   run        1 = count, 0 = park (phase 0, clk_out 0)
//   div_in     requested divisor N (DIV_W bits)
//   div_load   one-cycle load request for div_in
//   div_ack    one-cycle pulse: new divisor is now active
//   div_err    one-cycle pulse: load rejected (div_in < 2)
//   clk_out    divided clock, registered
//   tick       one-cycle enable per divided period, registered
//   phase_cnt  current phase 0..N-1, registered
//   tick_count 16-bit count of ticks (only when CLKDIV_TICK_CNT_EN is defined)
//
// Optional feature macro: CLKDIV_TICK_CNT_EN
module clk_divider_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] phase_cnt
`ifdef CLKDIV_TICK_CNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

  logic [DIV_W-1:0] n_q, pend_q;
  logic             pend_vld;

  logic             load_ok, eff_vld, wrap, apply, restart;
  logic [DIV_W-1:0] eff_val, n_nxt, k_nxt;

  // A valid load in this cycle overrides any older pending value and can be
  // applied in this very cycle if the period also ends here.
  always_comb begin
    load_ok = div_load && (div_in >= TWO);
    eff_vld = load_ok || pend_vld;
    eff_val = load_ok ? div_in : pend_q;
    wrap    = (phase_cnt == n_q - ONE);
    restart = !run || wrap;
    apply   = eff_vld && restart;
    n_nxt   = apply ? eff_val : n_q;
    k_nxt   = restart ? '0 : phase_cnt + ONE;
  end

  // clk_out/tick are computed from the next phase and next divisor so that
  // they stay a pure function of the registered (phase_cnt, N) pair. With
  // N >= 2, phase 0 always gives clk_out=0 and tick=0, which covers parking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
      n_q       <= DEF_N;
      pend_q    <= DEF_N;
      pend_vld  <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      div_ack   <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      phase_cnt <= k_nxt;
      n_q       <= n_nxt;
      clk_out   <= (k_nxt >= (n_nxt >> 1));
      tick      <= (k_nxt == n_nxt - ONE);
      div_ack   <= apply;
      div_err   <= div_load && (div_in < TWO);
      pend_vld  <= eff_vld && !apply;
      if (eff_vld) pend_q <= eff_val;
    end
  end

`ifdef CLKDIV_TICK_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            tick_count <= '0;
    else if (run && tick) tick_count <= tick_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
module tb_clk_divider_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] div_in = '0;
  logic       div_load = 1'b0;
  logic       div_ack, div_err, clk_out, tick;
  logic [7:0] phase_cnt;
`ifdef CLKDIV_TICK_CNT_EN
  logic [15:0] tick_count;
`endif

  clk_divider_prog #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .run(run), .div_in(div_in), .div_load(div_load),
    .div_ack(div_ack), .div_err(div_err), .clk_out(clk_out), .tick(tick),
    .phase_cnt(phase_cnt)
`ifdef CLKDIV_TICK_CNT_EN
    , .tick_count(tick_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: the divider is a phase k within a period of N cycles; a
  // requested divisor waits in a one-entry mailbox (-1 = empty) until the
  // period ends or the divider is parked.
  int m_k, m_n, m_pend, m_tc;
  bit m_ack, m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k = 0; m_n = 4; m_pend = -1; m_ack = 0; m_err = 0; m_tc = 0;
    end else begin
      int p;
      bit boundary;
      if (run && (m_k == m_n - 1)) m_tc = (m_tc + 1) % 65536;
      m_ack = 0;
      m_err = 0;
      p = m_pend;
      if (div_load) begin
        if (int'(div_in) >= 2) p = int'(div_in);
        else m_err = 1;
      end
      boundary = !run || (m_k == m_n - 1);
      m_k = boundary ? 0 : m_k + 1;
      if (boundary && p >= 0) begin
        m_n = p; m_ack = 1; p = -1;
      end
      m_pend = p;
    end
  end

  always @(negedge clk) begin
    chk("phase_cnt", int'(phase_cnt), m_k);
    chk("clk_out", int'(clk_out), int'(m_k >= m_n / 2));
    chk("tick", int'(tick), int'(m_k == m_n - 1));
    chk("div_ack", int'(div_ack), int'(m_ack));
    chk("div_err", int'(div_err), int'(m_err));
`ifdef CLKDIV_TICK_CNT_EN
    chk("tick_count", int'(tick_count), m_tc);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] p8c, p8t;
    logic [4:0] p5c, p5t;
    logic [2:0] p3c;
    logic [3:0] p2c;
    p8c = 8'b00110011; p8t = 8'b00010001;
    p5c = 5'b00111;    p5t = 5'b00001;
    p3c = 3'b011;      p2c = 4'b0101;

    // reset state
    cyc(); cyc();
    chk("rst_phase", int'(phase_cnt), 0);
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    reset = 0; run = 1;

    // default N=4
    for (int i = 0; i < 8; i++) begin
      chk("n4_clk", int'(clk_out), int'(p8c[7-i]));
      chk("n4_tick", int'(tick), int'(p8t[7-i]));
      cyc();
    end

    // load 5 mid-period
    cyc(); cyc();
    div_in = 8'd5; div_load = 1; cyc(); div_load = 0;
    chk("n5_noack", int'(div_ack), 0);
    cyc();
    chk("n5_ack", int'(div_ack), 1);
    for (int i = 0; i < 5; i++) begin
      chk("n5_clk", int'(clk_out), int'(p5c[4-i]));
      chk("n5_tick", int'(tick), int'(p5t[4-i]));
      cyc();
    end

    // rejected loads
    div_in = 8'd1; div_load = 1; cyc(); div_load = 0;
    chk("err1", int'(div_err), 1);
    div_in = 8'd0; div_load = 1; cyc(); div_load = 0;
    chk("err0", int'(div_err), 1);
    chk("err_noack", int'(div_ack), 0);
    cyc();
    chk("err_clear", int'(div_err), 0);

    // two loads in one period
    for (int w = 0; w < 12 && phase_cnt != 0; w++) cyc();
    chk("sync0", int'(phase_cnt), 0);
    div_in = 8'd6; div_load = 1; cyc();
    div_in = 8'd3; cyc(); div_load = 0;
    cyc(); cyc();
    chk("dbl_noack", int'(div_ack), 0);
    cyc();
    chk("dbl_ack", int'(div_ack), 1);
    for (int i = 0; i < 3; i++) begin
      chk("n3_clk", int'(clk_out), int'(p3c[2-i]));
      cyc();
    end
    chk("dbl_single_ack", int'(div_ack), 0);

    // park, load 2, resume
    cyc();
    run = 0; cyc();
    chk("park_phase", int'(phase_cnt), 0);
    chk("park_clk", int'(clk_out), 0);
    div_in = 8'd2; div_load = 1; cyc(); div_load = 0;
    chk("park_ack", int'(div_ack), 1);
    cyc();
    run = 1;
    for (int i = 0; i < 4; i++) begin
      chk("n2_clk", int'(clk_out), int'(p2c[3-i]));
      chk("n2_tick", int'(tick), int'(p2c[3-i]));
      cyc();
    end

    // back to N=4, then reset with a load pending at phase 2
    div_in = 8'd4; div_load = 1; cyc(); div_load = 0;
    cyc();
    chk("n4_ack", int'(div_ack), 1);
    cyc();
    div_in = 8'd5; div_load = 1; cyc(); div_load = 0;
    chk("pend_phase2", int'(phase_cnt), 2);
    #1 reset = 1;
    #1;
    chk("arst_phase", int'(phase_cnt), 0);
    chk("arst_clk", int'(clk_out), 0);
    chk("arst_tick", int'(tick), 0);
    cyc(); reset = 0;
`ifdef CLKDIV_TICK_CNT_EN
    chk("tc_rst", int'(tick_count), 0);
`endif
    for (int i = 0; i < 40; i++) begin
      if (i < 8) chk("post_rst_clk", int'(clk_out), int'(p8c[7-i]));
      chk("post_rst_noack", int'(div_ack), 0);
      cyc();
    end
`ifdef CLKDIV_TICK_CNT_EN
    chk("tc_40", int'(tick_count), 10);
`endif

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 19) != 0);
      div_load = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 49) == 0) div_in = 8'($urandom_range(0, 255));
      else div_in = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1; #1;
        chk("rnd_arst_phase", int'(phase_cnt), 0);
        cyc(); reset = 0;
      end else begin
        cyc();
      end
    end
    div_load = 0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
